// File: rtl/drac_pkg.sv
// Shared commit-stage types and helpers for the graduation-list scheduler.
package drac_pkg;

    typedef enum logic [1:0] {
        KIND_PLAIN = 2'd0,
        KIND_STORE = 2'd1,
        KIND_CSR   = 2'd2,
        KIND_FENCE = 2'd3
    } commit_kind_t;

    localparam logic [2:0] ST_RUN        = 3'd0;
    localparam logic [2:0] ST_WAIT_ST    = 3'd1;
    localparam logic [2:0] ST_WAIT_CSR   = 3'd2;
    localparam logic [2:0] ST_WAIT_FENCE = 3'd3;
    localparam logic [2:0] ST_DRAIN      = 3'd4;

    typedef enum logic [2:0] {
        CS_RUN        = ST_RUN,
        CS_WAIT_ST    = ST_WAIT_ST,
        CS_WAIT_CSR   = ST_WAIT_CSR,
        CS_WAIT_FENCE = ST_WAIT_FENCE,
        CS_DRAIN      = ST_DRAIN
    } commit_state_t;

    localparam int DRAIN_CYCLES_DEFAULT = 4;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/gl_commit_scheduler_if.sv
// Bundle between the graduation list / side units and the commit scheduler.
interface gl_commit_scheduler_if #(
    parameter int CNT_W = 64
);
    logic [1:0]       slot_valid_i;
    logic [1:0][1:0]  slot_kind_i;
    logic [1:0]       slot_ex_i;
    logic             gl_empty_i;
    logic             store_ack_i;
    logic             csr_done_i;
    logic             csr_ex_i;
    logic             fence_done_i;
    logic [1:0]       read_head_o;
    logic             store_commit_o;
    logic             csr_req_o;
    logic             fence_req_o;
    logic             flush_commit_o;
    logic             trap_o;
    logic [CNT_W-1:0] retired_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output slot_valid_i, slot_kind_i, slot_ex_i, gl_empty_i,
               store_ack_i, csr_done_i, csr_ex_i, fence_done_i,
        input  read_head_o, store_commit_o, csr_req_o, fence_req_o,
               flush_commit_o, trap_o, retired_cnt_o, stall_cnt_o
    );

    modport slave (
        input  slot_valid_i, slot_kind_i, slot_ex_i, gl_empty_i,
               store_ack_i, csr_done_i, csr_ex_i, fence_done_i,
        output read_head_o, store_commit_o, csr_req_o, fence_req_o,
               flush_commit_o, trap_o, retired_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/gl_commit_perf_cnt.sv
// Retired-instruction and commit-stall counters; both wrap silently.
module gl_commit_perf_cnt
    import drac_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [1:0]       read_head,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            retired_cnt <= retired_cnt + CNT_W'(popcount2(read_head));
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gl_commit_scheduler.sv
// Write-back commit sequencer: picks 0..2 GL entries to graduate per cycle and
// serializes stores, CSRs, fences and exceptions against their acknowledges.
module gl_commit_scheduler
    import drac_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 64
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    gl_commit_scheduler_if.slave  gl
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   drain_q, drain_d;
    logic         flush_q, flush_d;
    logic         trap_q, trap_d;
    logic [1:0]   read_head;
    logic         store_commit;
    logic         head_flush;
    logic         stall_inc;
    commit_kind_t kind0, kind1;

    assign kind0 = commit_kind_t'(gl.slot_kind_i[0]);
    assign kind1 = commit_kind_t'(gl.slot_kind_i[1]);

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        flush_d      = 1'b0;
        trap_d       = 1'b0;
        read_head    = 2'b00;
        store_commit = 1'b0;
        head_flush   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!gl.gl_empty_i && gl.slot_valid_i[0]) begin
                    if (gl.slot_ex_i[0]) begin
                        // Exception at head flushes in the same cycle it is seen.
                        head_flush = 1'b1;
                        state_d    = ST_DRAIN;
                        drain_d    = 4'(DRAIN_CYCLES);
                    end else begin
                        case (kind0)
                            KIND_PLAIN: begin
                                read_head[0] = 1'b1;
                                read_head[1] = gl.slot_valid_i[1] && !gl.slot_ex_i[1] &&
                                               (kind1 == KIND_PLAIN);
                            end
                            KIND_STORE: begin
                                store_commit = 1'b1;
                                state_d      = ST_WAIT_ST;
                            end
                            KIND_CSR:   state_d = ST_WAIT_CSR;
                            KIND_FENCE: state_d = ST_WAIT_FENCE;
                        endcase
                    end
                end
            end
            ST_WAIT_ST: begin
                if (gl.store_ack_i) begin
                    read_head = 2'b01;
                    state_d   = ST_RUN;
                end
            end
            ST_WAIT_CSR: begin
                // A finished CSR still flushes so younger ops see its side effects.
                if (gl.csr_done_i) begin
                    read_head = gl.csr_ex_i ? 2'b00 : 2'b01;
                    flush_d   = 1'b1;
                    trap_d    = gl.csr_ex_i;
                    state_d   = ST_DRAIN;
                    drain_d   = 4'(DRAIN_CYCLES);
                end
            end
            ST_WAIT_FENCE: begin
                if (gl.fence_done_i) begin
                    read_head = 2'b01;
                    state_d   = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= 4'd1) begin
                    state_d = ST_RUN;
                    drain_d = 4'd0;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_RUN;
            drain_q <= 4'd0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
        end
    end

    assign stall_inc = gl.slot_valid_i[0] && !gl.gl_empty_i &&
                       (read_head == 2'b00) && (state_q != ST_DRAIN);

    assign gl.read_head_o    = read_head;
    assign gl.store_commit_o = store_commit;
    assign gl.csr_req_o      = (state_q == ST_WAIT_CSR) && !gl.csr_done_i;
    assign gl.fence_req_o    = (state_q == ST_WAIT_FENCE);
    assign gl.flush_commit_o = head_flush | flush_q;
    assign gl.trap_o         = head_flush | trap_q;

    gl_commit_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .read_head   (read_head),
        .stall_inc   (stall_inc),
        .retired_cnt (gl.retired_cnt_o),
        .stall_cnt   (gl.stall_cnt_o)
    );

endmodule

// File: tb/tb_gl_commit_scheduler.sv
// Directed scoreboard bench for gl_commit_scheduler.
module tb_gl_commit_scheduler;
    import drac_pkg::*;

    localparam int CNT_W = 64;
    localparam logic [4:0] F_SC  = 5'b10000;
    localparam logic [4:0] F_CSR = 5'b01000;
    localparam logic [4:0] F_FEN = 5'b00100;
    localparam logic [4:0] F_FL  = 5'b00010;
    localparam logic [4:0] F_TR  = 5'b00001;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    gl_commit_scheduler_if #(.CNT_W(CNT_W)) gl ();

    gl_commit_scheduler #(
        .DRAIN_CYCLES (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .gl     (gl)
    );

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {gl.read_head_o, gl.store_commit_o, gl.csr_req_o, gl.fence_req_o,
                gl.flush_commit_o, gl.trap_o};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] k0, input logic [1:0] k1,
                         input logic [1:0] ex, input logic empty, input logic sack,
                         input logic cdone, input logic cex, input logic fdone);
        gl.slot_valid_i    = v;
        gl.slot_kind_i[0]  = k0;
        gl.slot_kind_i[1]  = k1;
        gl.slot_ex_i       = ex;
        gl.gl_empty_i      = empty;
        gl.store_ack_i     = sack;
        gl.csr_done_i      = cdone;
        gl.csr_ex_i        = cex;
        gl.fence_done_i    = fdone;
    endtask

    task automatic idle();
        drive(2'b00, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expectation is queued when the cycle's stimulus is applied and retired mid-cycle.
    task automatic step(input string tag, input logic [1:0] rh, input logic [4:0] flags);
        exp_t e;
        e.tag = tag;
        e.exp = {rh, flags};
        exp_q.push_back(e);
        @(negedge clk_i);
        e = exp_q.pop_front();
        check_eq(e.tag, 64'(outs()), 64'(e.exp));
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_cnts(input string tag, input logic [63:0] r, input logic [63:0] s);
        check_eq({tag, "_retired"}, gl.retired_cnt_o, r);
        check_eq({tag, "_stall"}, gl.stall_cnt_o, s);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("reset_outs", 64'(outs()), 64'd0);
        check_cnts("reset", 64'd0, 64'd0);
        rstn_i = 1'b1;

        // Dual plain graduation, then an empty GL which must not count as a stall
        drive(2'b11, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("dual_plain", 2'b11, 5'b0);
        drive(2'b11, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("gl_empty", 2'b00, 5'b0);
        idle();
        check_cnts("dual", 64'd20, 64'd0);

        // Store at head; an ack in the issue cycle is ignored
        drive(2'b11, KIND_STORE, KIND_PLAIN, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("st_issue", 2'b00, F_SC);
        drive(2'b11, KIND_STORE, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_wait1", 2'b00, 5'b0);
        step("st_wait2", 2'b00, 5'b0);
        drive(2'b11, KIND_STORE, KIND_PLAIN, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("st_ack", 2'b01, 5'b0);
        drive(2'b01, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_next_plain", 2'b01, 5'b0);
        idle();
        step("st_idle", 2'b00, 5'b0);
        check_cnts("store", 64'd22, 64'd3);

        // Exception on slot 1: slot 0 graduates alone, then head trap and drain
        drive(2'b11, KIND_PLAIN, KIND_PLAIN, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ex_slot1", 2'b01, 5'b0);
        drive(2'b01, KIND_PLAIN, KIND_PLAIN, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ex_head", 2'b00, F_FL | F_TR);
        drive(2'b11, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("ex_drain", 2'b00, 5'b0);
        drive(2'b11, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ex_resume", 2'b11, 5'b0);
        idle();
        check_cnts("ex", 64'd25, 64'd4);

        // CSR completing cleanly: serializing flush without trap
        drive(2'b01, KIND_CSR, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("csr_issue", 2'b00, 5'b0);
        drive(2'b01, KIND_CSR, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("csr_req1", 2'b00, F_CSR);
        step("csr_req2", 2'b00, F_CSR);
        drive(2'b01, KIND_CSR, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("csr_done", 2'b01, 5'b0);
        drive(2'b01, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("csr_flush", 2'b00, F_FL);
        for (int i = 0; i < 3; i++) step("csr_drain", 2'b00, 5'b0);
        step("csr_resume", 2'b01, 5'b0);
        idle();
        check_cnts("csr", 64'd27, 64'd7);

        // CSR raising an exception: trap, nothing retired
        drive(2'b01, KIND_CSR, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("csrx_issue", 2'b00, 5'b0);
        step("csrx_req", 2'b00, F_CSR);
        drive(2'b01, KIND_CSR, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("csrx_done", 2'b00, 5'b0);
        idle();
        step("csrx_trap", 2'b00, F_FL | F_TR);
        for (int i = 0; i < 3; i++) step("csrx_drain", 2'b00, 5'b0);
        check_cnts("csrx", 64'd27, 64'd10);

        // Fence
        drive(2'b01, KIND_FENCE, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fence_issue", 2'b00, 5'b0);
        step("fence_req", 2'b00, F_FEN);
        drive(2'b01, KIND_FENCE, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fence_done", 2'b01, F_FEN);
        idle();
        check_cnts("fence", 64'd28, 64'd12);

        // Reset in WAIT_ST; a late ack must not graduate anything
        drive(2'b01, KIND_STORE, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst_st_issue", 2'b00, F_SC);
        step("rst_st_wait", 2'b00, 5'b0);
        check_cnts("pre_rst", 64'd28, 64'd14);
        rstn_i = 1'b0;
        idle();
        #2;
        check_eq("midrst_outs", 64'(outs()), 64'd0);
        check_cnts("midrst", 64'd0, 64'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        drive(2'b00, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("late_ack", 2'b00, 5'b0);
        drive(2'b01, KIND_PLAIN, KIND_PLAIN, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("run_after_rst", 2'b01, 5'b0);
        idle();
        check_cnts("post_rst", 64'd1, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
